cic_interpolator: RTL and testbench
===================================

// Module: cic_interpolator
// PURPOSE
//  Q-stage CIC interpolator (D=1): comb section at input rate, zero-stuffing upsampler by R,
//  integrator section at output rate. Transmit-side counterpart of the DFE CIC decimator.
//  Runs on the 18 MHz system clock; one output sample every CLK_DIV clocks, one input every
//  R*CLK_DIV clocks. Unity DC gain, DATA_WIDTH in/out.
// PARAMETERS
//  DATA_WIDTH  16  input/output sample width, signed two's complement
//  R           4   interpolation factor; 1,2,4,8,16 only (other values: elaboration error)
//  Q           3   filter order (number of comb and integrator stages), 1..6
//  CLK_DIV     3   clk cycles per output sample (3 => 6 MHz output from 18 MHz clk), >=1
//  Derived: LOG2R = log2(R); W = DATA_WIDTH + (Q-1)*LOG2R internal width;
//           SHIFT = (Q-1)*LOG2R
// PORTS
//  clk        in   1           system clock
//  rst_n      in   1           reset, asynchronous, active-low
//  en         in   1           block enable; low = synchronous clear to IDLE
//  in_valid   in   1           x_in holds a valid sample
//  in_ready   out  1           block takes x_in this cycle if in_valid
//  x_in       in   DATA_WIDTH  input sample (low rate)
//  out_valid  out  1           one-cycle pulse: x_out updated
//  x_out      out  DATA_WIDTH  output sample (high rate), registered
//  underrun   out  1           sticky: input sample missing when required
// BEHAVIOUR
//  Reset (rst_n=0): x_out=0, out_valid=0, underrun=0, all comb delay/integrator regs=0,
//   div_cnt=0, phase=0, state=IDLE. Mid-operation reset aborts immediately, no partial output.
//  tick = (div_cnt==CLK_DIV-1); div_cnt wraps 0..CLK_DIV-1; phase wraps 0..R-1 on tick.
//  States:
//   IDLE: div_cnt/phase held 0, in_ready=1 every cycle, no ticks, out_valid=0.
//     in_valid&&in_ready&&en -> that cycle is treated as tick with phase=0; go RUN.
//   RUN: counters free-run. in_ready = tick && phase==0 (from counters, not from in_valid).
//     Accept = in_ready && in_valid. in_ready && !in_valid -> zero sample injected, underrun<=1.
//   en=0 (any state): next cycle state=IDLE, all datapath regs and counters=0, underrun=0,
//     out_valid=0; overrides a simultaneous accept (in_ready forced 0 when en=0).
//  Comb section (on accept or injected zero only): c0=sext(x_in) to W; stage i:
//   c_i = c_(i-1) - dly_i; dly_i <= c_(i-1). Combinational chain, delays registered.
//  Upsampler: integrator-0 input = c_Q on the phase-0 tick, 0 on the other R-1 ticks.
//  Integrators (update on tick only): integ_0 <= integ_0 + up_in;
//   integ_i <= integ_i + integ_(i-1) (previous-cycle value; registered chain).
//  Output: on every tick in RUN, x_out <= integ_(Q-1) >>> SHIFT (arithmetic, truncate, low
//   DATA_WIDTH bits), out_valid=1 for exactly that next cycle.
//  Latency: sample accepted on tick k first affects x_out on tick k+Q.
//  Arithmetic: all W-bit two's complement, wrap-around intended (no saturation); correct
//   for any in-range input since H(1)=R^(Q-1) and SHIFT removes it exactly.
//  R=1: plain pass of Q comb/integrator pairs = identity delayed by Q ticks.
//  Input held with in_valid=1 while in_ready=0: not consumed, no effect.
// TESTING
//  1 Impulse, R=2 Q=3 CLK_DIV=1: x_in=64 once then 0s -> x_out 16,48,48,16 then 0,
//    first nonzero 3 ticks after accept.
//  2 DC, defaults: x_in=1000 constantly -> x_out settles to 1000 exactly, out_valid every
//    3rd clk, in_ready every 12th clk.
//  3 Extremes, R=16 Q=5: x_in=-32768 then +32767 steps -> x_out settles to -32768/+32767, no
//    overflow glitches after settling.
//  4 Underrun, defaults: drop in_valid for one required slot -> underrun=1 and stays 1,
//    zero sample used, stream continues; en=0 one cycle -> underrun=0, state IDLE.
//  5 Clear/accept collision: en=0 with in_valid=1 on phase-0 tick -> sample not taken,
//    in_ready=0, all outputs 0 next cycle.
//  6 Async reset mid-stream (between ticks) -> all outputs 0 immediately, IDLE, first
//    sample after release accepted in the same cycle in_valid rises.

Source files
------------

// File: rtl/cic_interpolator.sv
// Q-stage CIC interpolator (differential delay 1).
// Comb section at input rate, zero-stuffing upsampler by R, integrator section at
// output rate. One output sample every CLK_DIV clocks, one input every R*CLK_DIV clocks.
// The R^(Q-1) DC gain is removed exactly by an arithmetic right shift.
module cic_interpolator #(
  parameter int DATA_WIDTH = 16,
  parameter int R          = 4,
  parameter int Q          = 3,
  parameter int CLK_DIV    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] x_in,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] x_out,
  output logic                  underrun
);

  localparam int LOG2R = $clog2(R);
  localparam int SHIFT = (Q - 1) * LOG2R;
  localparam int W     = DATA_WIDTH + SHIFT;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PH_W  = (R > 1) ? LOG2R : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(R - 1);

  if (!(R == 1 || R == 2 || R == 4 || R == 8 || R == 16)) begin : g_bad_r
    $error("cic_interpolator: R must be 1, 2, 4, 8 or 16");
  end
  if (Q < 1 || Q > 6) begin : g_bad_q
    $error("cic_interpolator: Q must be in 1..6");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("cic_interpolator: CLK_DIV must be at least 1");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state;
  logic [DIV_W-1:0]       div_cnt;
  logic [PH_W-1:0]        phase;
  logic signed [W-1:0]    comb_dly [1:Q];
  logic signed [W-1:0]    integ    [0:Q-1];

  logic                   run_tick;
  logic                   idle_take;
  logic                   tick;
  logic                   slot;
  logic                   accept;
  logic signed [W-1:0]    comb_c   [0:Q];
  logic signed [W-1:0]    up_in;

  // Tick/handshake decode: IDLE treats an accepted sample as a phase-0 tick, en=0 masks all
  always_comb begin
    run_tick  = (state == RUN) && (div_cnt == DIV_LAST);
    idle_take = (state == IDLE) && in_valid && en;
    in_ready  = en && ((state == IDLE) || (run_tick && (phase == '0)));
    tick      = en && (run_tick || idle_take);
    slot      = tick && ((state == IDLE) || (phase == '0));
    accept    = in_ready && in_valid;
  end

  // Comb chain and upsampler: a missing sample on a slot enters the combs as zero
  always_comb begin
    comb_c[0] = accept ? W'($signed(x_in)) : '0;
    for (int i = 1; i <= Q; i++) begin
      comb_c[i] = comb_c[i-1] - comb_dly[i];
    end
    up_in = slot ? comb_c[Q] : '0;
  end

  // Control state, rate counters, comb delays, integrators and registered output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_cnt   <= '0;
      phase     <= '0;
      underrun  <= 1'b0;
      out_valid <= 1'b0;
      x_out     <= '0;
      for (int i = 1; i <= Q; i++) comb_dly[i] <= '0;
      for (int i = 0; i < Q; i++)  integ[i]    <= '0;
    end else if (!en) begin
      state     <= IDLE;
      div_cnt   <= '0;
      phase     <= '0;
      underrun  <= 1'b0;
      out_valid <= 1'b0;
      x_out     <= '0;
      for (int i = 1; i <= Q; i++) comb_dly[i] <= '0;
      for (int i = 0; i < Q; i++)  integ[i]    <= '0;
    end else begin
      out_valid <= tick;

      case (state)
        IDLE: begin
          div_cnt <= '0;
          phase   <= '0;
          if (idle_take) begin
            state <= RUN;
            phase <= (R > 1) ? PH_W'(1) : '0;
          end
        end
        RUN: begin
          if (run_tick) begin
            div_cnt <= '0;
            phase   <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      if (slot && !in_valid) underrun <= 1'b1;

      if (slot) begin
        for (int i = 1; i <= Q; i++) comb_dly[i] <= comb_c[i-1];
      end

      if (tick) begin
        integ[0] <= integ[0] + up_in;
        for (int i = 1; i < Q; i++) integ[i] <= integ[i] + integ[i-1];
        x_out <= DATA_WIDTH'(integ[Q-1] >>> SHIFT);
      end
    end
  end

endmodule

// File: tb/tb_cic_interpolator.sv
// Directed testbench for cic_interpolator: three instances cover the impulse
// (R=2 Q=3 CLK_DIV=1), default DC/underrun/clear/reset cases, and extremes (R=16 Q=5).
module tb_cic_interpolator;

  localparam int DUT_A = 0;
  localparam int DUT_B = 1;
  localparam int DUT_C = 2;

  logic clk = 1'b0;
  logic rst_n;

  // 100 MHz-style bench clock; only the cycle count matters
  always #5 clk = ~clk;

  logic        a_en, a_in_valid, a_in_ready, a_out_valid, a_underrun;
  logic [15:0] a_x_in, a_x_out;
  logic        b_en, b_in_valid, b_in_ready, b_out_valid, b_underrun;
  logic [15:0] b_x_in, b_x_out;
  logic        c_en, c_in_valid, c_in_ready, c_out_valid, c_underrun;
  logic [15:0] c_x_in, c_x_out;

  cic_interpolator #(.DATA_WIDTH(16), .R(2), .Q(3), .CLK_DIV(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .x_in(a_x_in), .out_valid(a_out_valid), .x_out(a_x_out), .underrun(a_underrun)
  );

  cic_interpolator #(.DATA_WIDTH(16), .R(4), .Q(3), .CLK_DIV(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .x_in(b_x_in), .out_valid(b_out_valid), .x_out(b_x_out), .underrun(b_underrun)
  );

  cic_interpolator #(.DATA_WIDTH(16), .R(16), .Q(5), .CLK_DIV(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(c_en), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .x_in(c_x_in), .out_valid(c_out_valid), .x_out(c_x_out), .underrun(c_underrun)
  );

  int check_count = 0;
  int pass_count  = 0;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed == expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int which, input logic en_v, input logic valid_v,
                               input logic [15:0] x_v);
    case (which)
      DUT_A: begin a_en = en_v; a_in_valid = valid_v; a_x_in = x_v; end
      DUT_B: begin b_en = en_v; b_in_valid = valid_v; b_x_in = x_v; end
      default: begin c_en = en_v; c_in_valid = valid_v; c_x_in = x_v; end
    endcase
  endtask

  // Step negedges until dut_b offers a slot, with a bounded budget
  task automatic waitReadyB(input string tag);
    int n = 0;
    while (!b_in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, int'(b_in_ready), 1);
  endtask

  // Safety net so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  int imp_exp [9]  = '{0, 0, 0, 16, 48, 48, 16, 0, 0};
  int dip_exp [14] = '{1000, 1000, 1000, 937, 812, 625, 375, 250, 250, 375, 625, 812, 937, 1000};

  initial begin
    int ov_cnt;
    int ir_cnt;
    int idx;

    rst_n = 1'b0;
    applyStimulus(DUT_A, 1'b1, 1'b0, 16'd0);
    applyStimulus(DUT_B, 1'b1, 1'b0, 16'd0);
    applyStimulus(DUT_C, 1'b1, 1'b0, 16'd0);
    repeat (3) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_x_out",     int'($signed(b_x_out)), 0);
    checkOutput("rst_out_valid", int'(b_out_valid), 0);
    checkOutput("rst_underrun",  int'(b_underrun), 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_in_ready", int'(b_in_ready), 1);
    checkOutput("idle_no_valid", int'(b_out_valid), 0);

    // Impulse: 64 once then zeros
    $display("[TB] impulse R=2 Q=3 CLK_DIV=1");
    applyStimulus(DUT_A, 1'b1, 1'b1, 16'd64);
    @(negedge clk);
    applyStimulus(DUT_A, 1'b1, 1'b1, 16'd0);
    checkOutput("imp_ready_phase1", int'(a_in_ready), 0);
    for (int n = 0; n < 9; n++) begin
      if (n == 1) checkOutput("imp_ready_phase0", int'(a_in_ready), 1);
      checkOutput("imp_valid", int'(a_out_valid), 1);
      checkOutput($sformatf("imp_x_out[%0d]", n), int'($signed(a_x_out)), imp_exp[n]);
      @(negedge clk);
    end
    applyStimulus(DUT_A, 1'b0, 1'b0, 16'd0);

    // Extremes on R=16 Q=5: full-scale negative, then full-scale positive
    $display("[TB] extremes R=16 Q=5");
    applyStimulus(DUT_C, 1'b1, 1'b1, 16'h8000);
    repeat (200) @(negedge clk);
    for (int n = 0; n < 16; n++) begin
      checkOutput("ext_neg", int'($signed(c_x_out)), -32768);
      @(negedge clk);
    end
    applyStimulus(DUT_C, 1'b1, 1'b1, 16'h7FFF);
    repeat (200) @(negedge clk);
    for (int n = 0; n < 16; n++) begin
      checkOutput("ext_pos", int'($signed(c_x_out)), 32767);
      @(negedge clk);
    end
    checkOutput("ext_underrun", int'(c_underrun), 0);
    applyStimulus(DUT_C, 1'b0, 1'b0, 16'd0);

    // DC at defaults
    $display("[TB] DC 1000 defaults");
    applyStimulus(DUT_B, 1'b1, 1'b1, 16'd1000);
    repeat (150) @(negedge clk);
    ov_cnt = 0;
    ir_cnt = 0;
    for (int n = 0; n < 48; n++) begin
      if (b_in_ready) ir_cnt++;
      if (b_out_valid) begin
        ov_cnt++;
        checkOutput("dc_level", int'($signed(b_x_out)), 1000);
      end
      @(negedge clk);
    end
    checkOutput("dc_out_valid_rate", ov_cnt, 16);
    checkOutput("dc_in_ready_rate", ir_cnt, 4);
    checkOutput("dc_underrun", int'(b_underrun), 0);

    // Underrun: skip exactly one slot, zero sample enters, stream continues
    $display("[TB] underrun");
    waitReadyB("underrun_wait_slot");
    applyStimulus(DUT_B, 1'b1, 1'b0, 16'd1000);
    @(negedge clk);
    applyStimulus(DUT_B, 1'b1, 1'b1, 16'd1000);
    checkOutput("underrun_set", int'(b_underrun), 1);
    idx = 0;
    for (int cyc = 0; cyc < 60 && idx < 14; cyc++) begin
      if (b_out_valid) begin
        checkOutput($sformatf("underrun_dip[%0d]", idx), int'($signed(b_x_out)), dip_exp[idx]);
        idx++;
      end
      @(negedge clk);
    end
    checkOutput("underrun_dip_count", idx, 14);
    checkOutput("underrun_sticky", int'(b_underrun), 1);

    // One-cycle clear
    applyStimulus(DUT_B, 1'b0, 1'b1, 16'd1000);
    #1;
    checkOutput("clear_in_ready", int'(b_in_ready), 0);
    @(negedge clk);
    checkOutput("clear_underrun",  int'(b_underrun), 0);
    checkOutput("clear_out_valid", int'(b_out_valid), 0);
    checkOutput("clear_x_out",     int'($signed(b_x_out)), 0);
    applyStimulus(DUT_B, 1'b1, 1'b0, 16'd0);
    #1;
    checkOutput("clear_idle_ready", int'(b_in_ready), 1);

    // Clear colliding with a phase-0 slot
    $display("[TB] clear/accept collision");
    @(negedge clk);
    applyStimulus(DUT_B, 1'b1, 1'b1, 16'd1000);
    repeat (60) @(negedge clk);
    waitReadyB("collide_wait_slot");
    applyStimulus(DUT_B, 1'b0, 1'b1, 16'd5000);
    #1;
    checkOutput("collide_in_ready", int'(b_in_ready), 0);
    @(negedge clk);
    checkOutput("collide_x_out",     int'($signed(b_x_out)), 0);
    checkOutput("collide_out_valid", int'(b_out_valid), 0);
    checkOutput("collide_underrun",  int'(b_underrun), 0);
    applyStimulus(DUT_B, 1'b1, 1'b0, 16'd5000);
    #1;
    checkOutput("collide_idle_ready", int'(b_in_ready), 1);
    ov_cnt = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (b_out_valid) ov_cnt++;
    end
    checkOutput("collide_no_ticks", ov_cnt, 0);
    checkOutput("collide_still_zero", int'($signed(b_x_out)), 0);
    checkOutput("collide_no_underrun", int'(b_underrun), 0);

    // Asynchronous reset between ticks
    $display("[TB] async reset mid-stream");
    applyStimulus(DUT_B, 1'b1, 1'b1, 16'd1000);
    repeat (90) @(negedge clk);
    @(posedge clk);
    #3;
    checkOutput("pre_reset_level", int'($signed(b_x_out)), 1000);
    rst_n = 1'b0;
    #1;
    checkOutput("areset_x_out",     int'($signed(b_x_out)), 0);
    checkOutput("areset_out_valid", int'(b_out_valid), 0);
    checkOutput("areset_underrun",  int'(b_underrun), 0);
    applyStimulus(DUT_B, 1'b1, 1'b0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(DUT_B, 1'b1, 1'b1, 16'd2000);
    #1;
    checkOutput("post_reset_ready", int'(b_in_ready), 1);
    @(posedge clk);
    #1;
    checkOutput("post_reset_take_valid", int'(b_out_valid), 1);
    checkOutput("post_reset_ready_low", int'(b_in_ready), 0);
    repeat (150) @(negedge clk);
    checkOutput("post_reset_level", int'($signed(b_x_out)), 2000);
    checkOutput("post_reset_underrun", int'(b_underrun), 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
